// File: rtl/sdram_pkg.sv
// Shared SDRAM request types and address-field helpers.
// No logic, no latency.
package sdram_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 14;
    localparam int COL_W  = 10;
    localparam int DATA_W = 16;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;

    typedef struct packed {
        logic              we;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wdata;
    } sdram_cmd_t;

    // Flat addresses are packed {bank, row, col}, bank in the MSBs.
    function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: BANK_W];
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return addr[COL_W +: ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] addr);
        return addr[COL_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_fifo.sv
// Generic synchronous FIFO; a push is visible at the head one cycle later.
// Refuses pushes while full (no same-cycle bypass); flush wins over push and pop.
module sdram_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_FULL);
    assign empty    = (level == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// Request queue in front of the SDRAM controller: FIFO, read limit, open-row hint, read return.
// Push-to-cmd_valid 1 cycle, read data 1 cycle; req_ready drops when full, reads stall at MAX_RD.
module sdram_cmd_queue #(
    parameter int DEPTH  = 8,
    parameter int BANK_W = sdram_pkg::BANK_W,
    parameter int ROW_W  = sdram_pkg::ROW_W,
    parameter int COL_W  = sdram_pkg::COL_W,
    parameter int DATA_W = sdram_pkg::DATA_W,
    parameter int MAX_RD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [BANK_W+ROW_W+COL_W-1:0] req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_we,
    output logic [BANK_W-1:0]             cmd_bank,
    output logic [ROW_W-1:0]              cmd_row,
    output logic [COL_W-1:0]              cmd_col,
    output logic [DATA_W-1:0]             cmd_wdata,
    output logic                          cmd_row_hit,
    input  logic                          precharge_all,
    input  logic                          flush,
    input  logic                          ctl_rd_valid,
    input  logic [DATA_W-1:0]             ctl_rd_data,
    output logic                          usr_rd_valid,
    output logic [DATA_W-1:0]             usr_rd_data,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          err
);

    import sdram_pkg::*;

    localparam int RD_W  = $clog2(MAX_RD + 1);
    localparam int NBANK = 1 << BANK_W;
    localparam logic [RD_W-1:0] RD_LIMIT = RD_W'(MAX_RD);

    sdram_cmd_t        push_cmd;
    sdram_cmd_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              rd_pop;
    logic              head_blocked;
    logic [RD_W-1:0]   rd_cnt;
    logic [NBANK-1:0]  open_vld;
    logic [ROW_W-1:0]  open_row [NBANK];

    always_comb begin
        push_cmd       = '0;
        push_cmd.we    = req_we;
        push_cmd.bank  = addr_bank(req_addr);
        push_cmd.row   = addr_row(req_addr);
        push_cmd.col   = addr_col(req_addr);
        push_cmd.wdata = req_wdata;
    end

    assign req_ready    = !fifo_full;
    assign push         = req_valid && req_ready;
    // Only reads count against the outstanding limit; a write at the head always issues.
    assign head_blocked = !head.we && (rd_cnt == RD_LIMIT);
    assign cmd_valid    = !fifo_empty && !head_blocked;
    assign pop          = cmd_valid && cmd_ready;
    assign rd_pop       = pop && !head.we;

    sdram_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(sdram_cmd_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign cmd_we      = head.we;
    assign cmd_bank    = head.bank;
    assign cmd_row     = head.row;
    assign cmd_col     = head.col;
    assign cmd_wdata   = head.wdata;
    assign cmd_row_hit = cmd_valid && open_vld[head.bank] && (open_row[head.bank] == head.row);

    // Read data with nothing outstanding is a controller protocol error; the count saturates at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (ctl_rd_valid && (rd_cnt == '0)) begin
                err <= 1'b1;
            end
            if (rd_pop && !ctl_rd_valid) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else if (!rd_pop && ctl_rd_valid && (rd_cnt != '0)) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
        end
    end

    // A precharge coinciding with a pop still leaves the popped bank open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            open_vld <= '0;
        end else begin
            if (precharge_all) begin
                open_vld <= '0;
            end
            if (pop) begin
                open_vld[head.bank] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            open_row[head.bank] <= head.row;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            usr_rd_valid <= 1'b0;
            usr_rd_data  <= '0;
        end else begin
            usr_rd_valid <= ctl_rd_valid;
            usr_rd_data  <= ctl_rd_data;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Scoreboard bench for sdram_cmd_queue against a queue-based reference model.
module tb_sdram_cmd_queue;

    localparam int DEPTH  = 8;
    localparam int MAX_RD = 4;
    localparam int BANK_W = 2;
    localparam int ROW_W  = 14;
    localparam int COL_W  = 10;
    localparam int DATA_W = 16;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [ADDR_W-1:0]     req_addr = '0;
    logic [DATA_W-1:0]     req_wdata = '0;
    logic                  cmd_valid;
    logic                  cmd_ready = 1'b0;
    logic                  cmd_we;
    logic [BANK_W-1:0]     cmd_bank;
    logic [ROW_W-1:0]      cmd_row;
    logic [COL_W-1:0]      cmd_col;
    logic [DATA_W-1:0]     cmd_wdata;
    logic                  cmd_row_hit;
    logic                  precharge_all = 1'b0;
    logic                  flush = 1'b0;
    logic                  ctl_rd_valid = 1'b0;
    logic [DATA_W-1:0]     ctl_rd_data = '0;
    logic                  usr_rd_valid;
    logic [DATA_W-1:0]     usr_rd_data;
    logic [$clog2(DEPTH):0] level;
    logic                  err;

    sdram_cmd_queue #(
        .DEPTH (DEPTH), .BANK_W (BANK_W), .ROW_W (ROW_W),
        .COL_W (COL_W), .DATA_W (DATA_W), .MAX_RD (MAX_RD)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_we (cmd_we),
        .cmd_bank (cmd_bank), .cmd_row (cmd_row), .cmd_col (cmd_col),
        .cmd_wdata (cmd_wdata), .cmd_row_hit (cmd_row_hit),
        .precharge_all (precharge_all), .flush (flush),
        .ctl_rd_valid (ctl_rd_valid), .ctl_rd_data (ctl_rd_data),
        .usr_rd_valid (usr_rd_valid), .usr_rd_data (usr_rd_data),
        .level (level), .err (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        int unsigned bank;
        int unsigned row;
        int unsigned col;
        int unsigned data;
    } req_t;

    req_t        mq[$];
    int unsigned rdq[$];
    int          outst = 0;
    bit          m_err = 1'b0;
    bit          ov[4];
    int unsigned orow[4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        rdq.delete();
        outst = 0;
        m_err = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ov[b]   = 1'b0;
            orow[b] = 0;
        end
    endfunction

    // Monitor: checks DUT outputs against the model, then advances the model for the coming edge.
    always @(negedge clk) begin : mon
        bit    ev;
        bit    hit;
        bit    popped;
        bit    rpop;
        int    sz;
        req_t  h;
        req_t  n;
        if (rst) begin
            if (rdq.size() > 0) begin
                check("usr_rd_valid", usr_rd_valid, 1);
                check("usr_rd_data", usr_rd_data, rdq.pop_front());
            end else begin
                check("usr_rd_valid", usr_rd_valid, 0);
            end

            sz = mq.size();
            ev = (sz > 0) && !(!mq[0].we && outst == MAX_RD);
            check("cmd_valid", cmd_valid, ev);
            check("req_ready", req_ready, sz < DEPTH);
            check("level", level, sz);
            check("err", err, m_err);
            if (ev) begin
                hit = ov[mq[0].bank] && (orow[mq[0].bank] == mq[0].row);
                check("cmd_we", cmd_we, mq[0].we);
                check("cmd_bank", cmd_bank, mq[0].bank);
                check("cmd_row", cmd_row, mq[0].row);
                check("cmd_col", cmd_col, mq[0].col);
                if (mq[0].we) check("cmd_wdata", cmd_wdata, mq[0].data);
                check("cmd_row_hit", cmd_row_hit, hit);
            end else begin
                check("cmd_row_hit", cmd_row_hit, 0);
            end

            popped = ev && cmd_ready;
            rpop   = 1'b0;
            if (popped) begin
                h    = mq.pop_front();
                rpop = !h.we;
            end
            if (precharge_all) begin
                for (int b = 0; b < 4; b++) ov[b] = 1'b0;
            end
            if (popped) begin
                ov[h.bank]   = 1'b1;
                orow[h.bank] = h.row;
            end

            if (ctl_rd_valid && outst == 0) m_err = 1'b1;
            if (rpop && !ctl_rd_valid) outst = outst + 1;
            else if (!rpop && ctl_rd_valid && outst > 0) outst = outst - 1;
            if (ctl_rd_valid) rdq.push_back(ctl_rd_data);

            if (flush) begin
                mq.delete();
            end else if (req_valid && sz < DEPTH) begin
                n.we   = req_we;
                n.bank = req_addr / (1 << (ROW_W + COL_W));
                n.row  = (req_addr / (1 << COL_W)) % (1 << ROW_W);
                n.col  = req_addr % (1 << COL_W);
                n.data = req_wdata;
                mq.push_back(n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit we, input int unsigned bank, input int unsigned row,
                           input int unsigned col, input int unsigned data);
        req_we    = we;
        req_addr  = ADDR_W'((bank << (ROW_W + COL_W)) | (row << COL_W) | col);
        req_wdata = DATA_W'(data);
    endtask

    task automatic push_req(input bit we, input int unsigned bank, input int unsigned row,
                            input int unsigned col, input int unsigned data);
        set_req(we, bank, row, col, data);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic rd_return(input int unsigned data);
        ctl_rd_valid = 1'b1;
        ctl_rd_data  = DATA_W'(data);
        tick();
        ctl_rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_level", level, 0);
        check("rst_usr_rd_valid", usr_rd_valid, 0);
        check("rst_usr_rd_data", usr_rd_data, 0);
        check("rst_err", err, 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // 1: single write, then a second write to the now-open row.
        cmd_ready = 1'b1;
        push_req(1, 1, 'h0123, 'h005, 'hBEEF);
        check("t1_cmd_valid", cmd_valid, 1);
        check("t1_row_hit", cmd_row_hit, 0);
        tick();
        push_req(1, 1, 'h0123, 'h006, 'hCAFE);
        check("t1_second_hit", cmd_row_hit, 1);
        tick();

        // 2: fill past capacity while the controller stalls, then drain.
        cmd_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_req(1, i % 4, 'h0123, i, 'h1000 + i);
        check("t2_level_full", level, DEPTH);
        check("t2_req_ready", req_ready, 0);
        cmd_ready = 1'b1;
        repeat (10) tick();

        // 3: read limit stalls the fifth read until data returns.
        for (int i = 0; i < 5; i++) push_req(0, i % 4, 'h0123, i, 0);
        repeat (3) tick();
        check("t3_level", level, 1);
        check("t3_blocked", cmd_valid, 0);
        rd_return('h1234);
        check("t3_usr_valid", usr_rd_valid, 1);
        check("t3_usr_data", usr_rd_data, 'h1234);
        check("t3_unblocked", cmd_valid, 1);
        tick();
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) rd_return($urandom);
        tick();

        // 4: precharge together with a pop to bank 2.
        push_req(1, 2, 'h10, 7, 'h2222);
        cmd_ready     = 1'b1;
        precharge_all = 1'b1;
        tick();
        cmd_ready     = 1'b0;
        precharge_all = 1'b0;
        push_req(1, 2, 'h10, 8, 'h3333);
        check("t4_bank2_hit", cmd_row_hit, 1);
        pop_one();
        for (int b = 0; b < 4; b++) begin
            if (b == 2) continue;
            push_req(1, b, 'h0123, 9, 'h4444);
            check("t4_closed_miss", cmd_row_hit, 0);
            pop_one();
        end

        // 5: flush with a concurrent push; outstanding read survives.
        push_req(0, 0, 'h55, 1, 0);
        pop_one();
        for (int i = 0; i < 3; i++) push_req(1, 3, 'h66, i, 'h5000 + i);
        check("t5_level3", level, 3);
        set_req(1, 1, 'h77, 3, 'h7777);
        req_valid = 1'b1;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("t5_level0", level, 0);
        check("t5_cmd_valid", cmd_valid, 0);
        rd_return('hABCD);
        check("t5_no_err", err, 0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            req_valid     = ($urandom_range(0, 9) < 6);
            set_req($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 1023), $urandom_range(0, 65535));
            cmd_ready     = ($urandom_range(0, 9) < 7);
            precharge_all = ($urandom_range(0, 19) == 0);
            flush         = ($urandom_range(0, 39) == 0);
            ctl_rd_valid  = (outst > 0) && ($urandom_range(0, 2) == 0);
            ctl_rd_data   = DATA_W'($urandom);
            tick();
        end
        req_valid     = 1'b0;
        cmd_ready     = 1'b0;
        precharge_all = 1'b0;
        flush         = 1'b0;
        ctl_rd_valid  = 1'b0;
        tick();

        // 6: stray read data sets the sticky error; reset clears it.
        cmd_ready = 1'b1;
        repeat (DEPTH + 2) begin
            if (outst > 0) rd_return($urandom);
            else tick();
        end
        cmd_ready = 1'b0;
        while (outst > 0) rd_return($urandom);
        rd_return('h0BAD);
        check("t6_err_set", err, 1);
        repeat (5) tick();
        check("t6_err_sticky", err, 1);

        push_req(1, 0, 'h1, 1, 'h1);
        push_req(0, 1, 'h2, 2, 'h2);
        do_reset();
        push_req(1, 3, 'h3FFF, 'h3FF, 'hFFFF);
        check("post_rst_valid", cmd_valid, 1);
        pop_one();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_queue.md
Name: sdram_cmd_queue

Overview:
- User-side request front-end that sits directly upstream of the SDRAM controller (`sdram`).
- Buffers read and write requests in a FIFO and splits each flat address into bank, row and column fields.
- Presents one command at a time to the controller over a valid/ready handshake, with a per-bank open-row hit hint.
- Limits the number of outstanding reads and returns read data to the user one cycle after the controller delivers it.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- BANK_W, 2, bank field width; matches SDRAM_BankAddr.
- ROW_W, 14, row field width; matches SDRAM_Addr.
- COL_W, 10, column field width.
- DATA_W, 16, data width; matches SDRAM_data.
- MAX_RD, 4, maximum number of reads issued but not yet returned.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  user request valid.
- req_ready  out  1  queue can accept a request (not full).
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  BANK_W+ROW_W+COL_W  flat address, packed as {bank, row, col}.
- req_wdata  in  DATA_W  write data; ignored for reads.
- cmd_valid  out  1  command available to the controller.
- cmd_ready  in  1  controller accepts the command.
- cmd_we  out  1  command direction.
- cmd_bank  out  BANK_W  bank field.
- cmd_row  out  ROW_W  row field.
- cmd_col  out  COL_W  column field.
- cmd_wdata  out  DATA_W  write data.
- cmd_row_hit  out  1  head command targets the currently open row of its bank.
- precharge_all  in  1  controller closed all rows (precharge or refresh).
- flush  in  1  synchronous clear of queued requests.
- ctl_rd_valid  in  1  controller read data valid.
- ctl_rd_data  in  DATA_W  controller read data.
- usr_rd_valid  out  1  registered read return to the user.
- usr_rd_data  out  DATA_W  registered read data.
- level  out  $clog2(DEPTH)+1  current number of queued entries.
- err  out  1  sticky: read data arrived with zero reads outstanding.

Behaviour:
- **Reset (rst low):**
  - cmd_valid=0, req_ready=1, level=0, usr_rd_valid=0, usr_rd_data=0, err=0.
  - Outstanding-read counter=0; all open-row entries invalid.
  - Reset mid-transfer discards every queued and outstanding request.
- **Push:**
  - Occurs when req_valid && req_ready.
  - req_ready = !full, taken from registered state. There is no same-cycle bypass, so a full queue refuses a push even while popping.
- **Latency:** a push into an empty queue is visible on cmd_valid on the next cycle. The cmd_* fields come from the FIFO head and are stable while cmd_valid && !cmd_ready.
- **cmd_valid:** equals !empty && !(head is read && outstanding==MAX_RD). A write at the head is never blocked by the read limit.
- **Pop:** occurs when cmd_valid && cmd_ready. A read pop increments the outstanding counter.
- **Outstanding counter:**
  - ctl_rd_valid decrements it.
  - A read pop and ctl_rd_valid in the same cycle leave it unchanged.
  - ctl_rd_valid with the counter at 0 leaves the counter at 0 and sets err.
- **Level:** simultaneous push and pop leaves level unchanged. Pointers wrap modulo DEPTH.
- **Read return:** usr_rd_valid/usr_rd_data register ctl_rd_valid/ctl_rd_data, giving exactly 1 cycle of latency in request order.
- **Open-row table:**
  - One {valid, row} entry per bank.
  - cmd_row_hit = entry[cmd_bank].valid && entry[cmd_bank].row==cmd_row && cmd_valid.
  - On every pop, entry[cmd_bank] <= {1, cmd_row}.
  - precharge_all invalidates all entries. If it coincides with a pop, clear first, then the popped bank's entry is set.
- **flush:**
  - Empties the FIFO (level=0, cmd_valid=0 next cycle).
  - A push in the same cycle is dropped.
  - The outstanding counter and the open-row table are not affected.
- **Full boundary:** level==DEPTH drives req_ready=0. Exactly DEPTH entries are storable.

Decomposition:
- Package sdram_pkg holds:
  - BANK_W, ROW_W, COL_W, DATA_W constants;
  - the typedef sdram_cmd_t {we, bank, row, col, wdata};
  - address split helper functions.
- One sub-module, sdram_fifo: a generic synchronous FIFO (DEPTH, width = $bits(sdram_cmd_t)) with push, pop, flush, full, empty and level.
- The read limit, open-row table and read return stay in sdram_cmd_queue.

Test Plan:
1. Reset, push a write {bank=1, row=0x0123, col=0x005, data=0xBEEF} with cmd_ready=1.
   → cmd_valid high 1 cycle after the push, fields match, cmd_row_hit=0; a second write to the same bank/row gives cmd_row_hit=1.
2. Hold cmd_ready=0 and push 9 requests with DEPTH=8.
   → req_ready falls after the 8th, level=8, the 9th is not accepted; releasing cmd_ready drains 8 commands in order.
3. Issue 5 reads with MAX_RD=4 and no ctl_rd_valid.
   → 4 pops, then cmd_valid=0 with level=1; one ctl_rd_valid=0x1234 gives usr_rd_valid/0x1234 on the next cycle and the 5th read issues.
4. Assert precharge_all in the same cycle as a pop to bank 2, row 0x10.
   → bank 2 entry valid with row 0x10; banks 0, 1 and 3 invalid.
5. With 3 entries queued, assert flush together with req_valid.
   → level=0 and cmd_valid=0 next cycle, the new request is dropped, the outstanding count is preserved.
6. Pulse ctl_rd_valid with no reads outstanding.
   → err=1 and stays set; the counter stays 0; only reset clears err.
